// File: rtl/spi_slave_4byte.sv
// ---------------------------------------------------------------------------
// spi_slave_4byte
//
// SPI responder. SPI_CLK, SPI_SS and MOSI are oversampled in the CLK_IN
// domain, so every flop in this block runs on CLK_IN. Each frame receives C
// bits on MOSI (LSB-first) and returns a preloaded C-bit word on MISO
// (MSB-first). All four CPOL/CPHA modes are supported.
//
// Optional feature macro: SPI_SLAVE_ERR_EN
//   defined   : err is a sticky flag set by a short frame or an underrun,
//               cleared only by RST.
//   undefined : err is tied low and no error-detection logic exists.
//
// Ports
//   CLK_IN     in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   SPI_CLK    in   SPI clock from master (asynchronous)
//   SPI_SS     in   slave select, active-low (asynchronous)
//   MOSI       in   serial data from master (asynchronous)
//   MISO       out  serial data to master (0 when not shifting)
//   MISO_OE    out  high while selected; pad tristates MISO when low
//   CPOL       in   clock idle level, static during a frame
//   CPHA       in   0 = sample leading edge, 1 = sample trailing edge
//   din        in   next reply word
//   din_valid  in   din is offered
//   din_ready  out  holding register empty
//   dout       out  last complete received word
//   valid      out  one-cycle pulse when dout is updated
//   err        out  sticky error flag (see macro above)
//   state_dbg  out  current FSM state (0 IDLE, 1 SHIFT, 2 DRAIN)
//
// Handshake: a word moves from din into the holding register on any rising
// CLK_IN edge where din_valid and din_ready are both high; din_ready drops
// the following cycle and rises again when a frame takes the word.
// ---------------------------------------------------------------------------
module spi_slave_4byte #(
  parameter int C = 32
) (
  input  logic         CLK_IN,
  input  logic         RST,
  input  logic         SPI_CLK,
  input  logic         SPI_SS,
  input  logic         MOSI,
  output logic         MISO,
  output logic         MISO_OE,
  input  logic         CPOL,
  input  logic         CPHA,
  input  logic [C-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [C-1:0] dout,
  output logic         valid,
  output logic         err,
  output logic [1:0]   state_dbg
);

  localparam int CW = $clog2(C + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // -------------------------------------------------------------------------
  // Input synchronizers and edge history
  // -------------------------------------------------------------------------
  logic sclk_m, sclk_s, sclk_d;
  logic ss_m, ss_s, ss_d;
  logic mosi_m, mosi_s;
  logic ss_armed;

  // ss_armed stays low after reset until SS has been seen high, so a master
  // that keeps SS low through a reset cannot restart a frame without first
  // releasing SS.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      sclk_m   <= 1'b0;
      sclk_s   <= 1'b0;
      sclk_d   <= 1'b0;
      ss_m     <= 1'b0;
      ss_s     <= 1'b0;
      ss_d     <= 1'b1;
      mosi_m   <= 1'b0;
      mosi_s   <= 1'b0;
      ss_armed <= 1'b0;
    end else begin
      sclk_m <= SPI_CLK;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      ss_m   <= SPI_SS;
      ss_s   <= ss_m;
      ss_d   <= ss_s;
      mosi_m <= MOSI;
      mosi_s <= mosi_m;
      if (ss_s) begin
        ss_armed <= 1'b1;
      end
    end
  end

  logic sclk_rise, sclk_fall;
  logic ss_fall, ss_rise;
  logic sample_edge, drive_edge;

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ss_armed & ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling
  // edge; the opposite edge always drives the next MISO bit.
  assign sample_edge = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;
  assign drive_edge  = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  logic [C-1:0]  hold_q;
  logic          hold_full;
  logic [C-1:0]  tx_sr;
  logic [C-1:0]  rx_sr;
  logic [CW-1:0] bitcnt;
  logic          skip_drive;
  logic          done_q;
  logic          miso_q;

  logic start_frame;
  logic last_sample;
  logic in_shift;
  logic take_din;

  assign in_shift    = (state_q == ST_SHIFT);
  assign start_frame = (state_q == ST_IDLE) & ss_fall;
  assign last_sample = in_shift & sample_edge & (bitcnt == CW'(C - 1));
  assign take_din    = din_valid & ~hold_full;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and output enable
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    MISO_OE = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        MISO_OE = 1'b1;
        // A final sample edge that coincides with SS release still
        // completes the frame; the frame then closes straight to IDLE.
        if (last_sample) begin
          state_d = ss_rise ? ST_IDLE : ST_DRAIN;
        end else if (ss_rise) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        MISO_OE = 1'b1;
        if (ss_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Holding register, shift registers, bit counter, received word
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      hold_q     <= '0;
      hold_full  <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bitcnt     <= '0;
      skip_drive <= 1'b0;
      done_q     <= 1'b0;
      valid      <= 1'b0;
      dout       <= '0;
      miso_q     <= 1'b0;
    end else begin
      // dout is written on the completing edge, valid follows a cycle later.
      done_q <= last_sample;
      valid  <= done_q;

      // Registered MISO gives a fixed pin-to-pin latency from drive edge.
      miso_q <= in_shift ? tx_sr[C-1] : 1'b0;

      // A handshake is only possible while empty, so it never collides with
      // a frame start that takes a full holding register. If it lands in the
      // same cycle as an underrun start, the word stays held for next frame.
      if (take_din) begin
        hold_q    <= din;
        hold_full <= 1'b1;
      end

      if (start_frame) begin
        if (hold_full) begin
          tx_sr     <= hold_q;
          hold_full <= 1'b0;
        end else begin
          tx_sr <= '0;
        end
        rx_sr      <= '0;
        bitcnt     <= '0;
        // With CPHA=1 the first edge of the frame is a drive edge, but the
        // MSB is already on MISO, so that one edge must not shift.
        skip_drive <= CPHA;
      end

      if (in_shift) begin
        if (sample_edge) begin
          rx_sr  <= {mosi_s, rx_sr[C-1:1]};
          bitcnt <= bitcnt + CW'(1);
          if (last_sample) begin
            dout <= {mosi_s, rx_sr[C-1:1]};
          end
        end
        if (drive_edge) begin
          if (skip_drive) begin
            skip_drive <= 1'b0;
          end else begin
            tx_sr <= {tx_sr[C-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign MISO      = miso_q;
  assign din_ready = ~hold_full;
  assign state_dbg = state_q;

  // -------------------------------------------------------------------------
  // Sticky error flag
  // -------------------------------------------------------------------------
`ifdef SPI_SLAVE_ERR_EN
  logic err_q;
  logic underrun;
  logic short_frame;

  assign underrun    = start_frame & ~hold_full;
  assign short_frame = in_shift & ss_rise & ~last_sample & (bitcnt != '0);

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (underrun | short_frame) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/spi_slave_4byte.md
# spi_slave_4byte

Responder end of the team's SPI link: accepts frames from an SPI master (external, or `spi_master_4byte` on another board) and returns a parallel word per frame. Oversamples `SPI_CLK`, `SPI_SS` and `MOSI` in the `CLK_IN` domain, so no logic runs on the SPI clock. It receives `C` bits per frame and transmits a preloaded `C`-bit word back on `MISO` in the same frame. Bit order matches our master: MOSI is LSB-first and MISO is MSB-first.

## Interface
- `C`, 32, frame length in bits (2..32).
- `CLK_IN`  in  1  system clock; all logic on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `SPI_CLK`  in  1  SPI clock from master, asynchronous.
- `SPI_SS`  in  1  slave select, active-low, asynchronous.
- `MOSI`  in  1  serial data from master, asynchronous.
- `MISO`  out  1  serial data to master.
- `MISO_OE`  out  1  high while selected; the pad tristates `MISO` when low.
- `CPOL`  in  1  clock idle level; static during a frame.
- `CPHA`  in  1  0 = sample on leading edge, 1 = sample on trailing edge; static during a frame.
- `din`  in  C  next reply word.
- `din_valid`  in  1  `din` is offered.
- `din_ready`  out  1  holding register empty; a transfer occurs when `din_valid & din_ready`.
- `dout`  out  C  last complete received word.
- `valid`  out  1  one-cycle pulse when `dout` is updated.
- `err`  out  1  sticky error flag (see Configuration).

## Operation
- **Input synchronizers:** 2-flop synchronizers on `SPI_CLK`, `SPI_SS`, `MOSI`, plus one history flop for edge detection on `SPI_CLK` and `SPI_SS`.
- **Edge selection:** sample edge is rising when `CPOL^CPHA==0`, else falling. The drive edge is the opposite edge.
- **Holding register:** loaded from `din` on handshake; `din_ready` goes low the next cycle.
- **States:**
  - IDLE: `MISO_OE=0`. On a synchronized `SPI_SS` falling edge:
    - copy the holding register to `tx_sr` if full (then `din_ready`←1), else load 0 and flag underrun;
    - clear `rx_sr` and `bitcnt`;
    - go to SHIFT.
  - SHIFT:
    - `MISO_OE=1`.
    - On a sample edge: `rx_sr <= {MOSI_s, rx_sr[C-1:1]}`, `bitcnt++`.
    - On a drive edge: `tx_sr <= {tx_sr[C-2:0],1'b0}`, except the first drive edge when `CPHA=1`, which does not shift. For `CPHA=0`, MSB is on `MISO` from SS assertion.
    - When `bitcnt` reaches C on a sample edge: `dout <= {MOSI_s, rx_sr[C-1:1]}`, pulse `valid` next cycle, go to DRAIN.
    - SS rising edge in SHIFT: short frame; `dout`/`valid` untouched; go to IDLE.
  - DRAIN: `MISO=0`, `MISO_OE=1`. Extra edges are ignored. SS rising edge → IDLE.
- **Output driving:** `MISO = tx_sr[C-1]` in SHIFT; 0 otherwise.
- **Simultaneous events:**
  - An SS rising edge and the C-th sample edge in the same cycle complete the frame (valid pulses), then go to IDLE.
  - A `din` handshake in the same cycle as the SS falling edge: the new word is not used for this frame; it stays held for the next frame.
- **Reset mid-frame:** go to IDLE, dropping the frame. A new frame starts only on a fresh SS falling edge, so the master must release SS first.

## Timing
- **Reset values:** `MISO=0`, `MISO_OE=0`, `dout=0`, `valid=0`, `din_ready=1`, `err=0`, state IDLE; synchronizers cleared with `SPI_SS` history = 1.
- **Input latency:** pin to internal edge detect is 3 `CLK_IN` cycles.
- **`valid` latency:** asserts 4 cycles after the final sample edge at the pin.
- **`MISO` update:** changes 4 cycles after the drive edge at the pin.
- **SPI clock limit:** `SPI_CLK` high and low times must each be ≥ 4 `CLK_IN` periods, giving a max SPI_CLK of `CLK_IN`/8.
- **SS setup:** ≥ 4 `CLK_IN` periods from SS falling to the first `SPI_CLK` edge, and from SS rising to the next SS falling.
- **`din` timing:** a handshake completing ≥ 1 cycle before the synchronized SS fall is used for that frame.

## Configuration
- Macro: `SPI_SLAVE_ERR_EN`.
- **Defined:** `err` is set by a short frame (SS released with 0 < `bitcnt` < C) or by an underrun (frame starts with the holding register empty). It is cleared only by `RST`.
- **Undefined:** `err` is tied to 0, and no error-detection logic is built. Short frames and underruns still behave as in Operation: discarded, or zeros sent.

## Test plan
- **Mode 0, C=32, basic frame:** preload `din=0xA5A5_0F0F`; master sends `0x1234_5678` LSB-first. Required: `dout=0x1234_5678` with one `valid` pulse; master receives 0xA5A50F0F MSB-first; `din_ready` returns to 1 at SS fall.
- **All four CPOL/CPHA modes:** SPI_CLK = `CLK_IN`/8, `din=0x8000_0001`, MOSI `0xFFFF_0000`. Required in every mode: `dout=0xFFFF_0000`; first MISO bit 1, last bit 1, others 0.
- **Short frame:** SS released after 10 bits. Required: no `valid`; `dout` keeps its prior value; `err=1` with the macro, 0 without; next full frame is received correctly.
- **Underrun, then extra clocks:** no `din` loaded; a frame of 40 clocks. Required: MISO is 0 for all 40 bits; `valid` pulses once after bit 32; `err=1` with the macro.
- **Reset mid-frame:** `RST` for 1 cycle at bit 16 with SS held low. Required: all outputs at reset values; no `valid` for the remaining clocks; a frame after SS re-asserts works.
- **Back-to-back frames:** two frames with the 4-cycle SS gap, new `din` loaded in between. Required: two `valid` pulses with correct words, and the second reply word is used.
